// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a one-byte holding buffer and store back-pressure
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  subfunction_3,
  input  logic        request_write,
  input  logic        request_read,
  output logic        clk_stall,
  output logic [31:0] read_data,
  output logic        decoding_error,
  output logic        tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;
  logic [CW-1:0] count, count_next;
  logic [2:0] bit_index, bit_index_next;
  logic [7:0] shifter, shifter_next, holding, last_written;
  logic holding_full, hit, tx_hit, st_hit, bad_off, wr_ok, rd_ok, wr_err, rd_err;
  logic accept, done, load, busy, tx_next, unused;
  assign hit = address[31:4] == BASE_ADDRESS[31:4];
  assign tx_hit = hit & (address[3:2] == 2'd0);
  assign st_hit = hit & (address[3:2] == 2'd1);
  assign bad_off = hit & address[3];
  assign wr_ok = subfunction_3 inside {3'b000, 3'b001, 3'b010};
  assign rd_ok = subfunction_3 inside {3'b010, 3'b100};
  assign wr_err = request_write & (bad_off | st_hit | (hit & ~wr_ok));
  assign rd_err = request_read & hit & (bad_off | ~rd_ok);
  assign decoding_error = wr_err | rd_err;
  assign clk_stall = request_write & tx_hit & holding_full;
  assign accept = request_write & tx_hit & wr_ok & ~holding_full;
  assign busy = (state != IDLE) | holding_full;
  assign read_data = (~request_read | rd_err) ? 32'd0 :
                     tx_hit ? {24'd0, last_written} :
                     st_hit ? {30'd0, holding_full, busy} : 32'd0;
  assign unused = ^{write_data[31:8], address[1:0]};
  assign done = count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      bit_index <= '0;
      shifter <= '0;
      holding <= '0;
      holding_full <= 1'b0;
      last_written <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_next;
      count <= count_next;
      bit_index <= bit_index_next;
      shifter <= shifter_next;
      tx <= tx_next;
      holding <= accept ? write_data[7:0] : holding;
      last_written <= accept ? write_data[7:0] : last_written;
      holding_full <= accept | (holding_full & ~load);
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = holding_full ? START : IDLE;
      START:   state_next = done ? DATA : START;
      DATA:    state_next = (done && bit_index == 3'd7) ? STOP : DATA;
      STOP:    state_next = done ? (holding_full ? START : IDLE) : STOP;
      default: state_next = IDLE;
    endcase
  end
  always_comb begin
    load = holding_full & ((state == IDLE) | ((state == STOP) & done));
    shifter_next = load ? holding : (state == DATA && done) ? {1'b0, shifter[7:1]} : shifter;
    bit_index_next = (state == START) ? 3'd0 : (state == DATA && done) ? bit_index + 3'd1 : bit_index;
    count_next = (state_next != state || (state == DATA && done)) ? RELOAD : done ? count : count - 1'b1;
    tx_next = (state_next == START) ? 1'b0 : (state_next == DATA) ? shifter_next[0] : 1'b1;
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx at four clocks per bit
module tb_mmio_uart_tx;
  logic clk = 1'b0;
  logic reset, request_write, request_read, clk_stall, decoding_error, tx;
  logic [31:0] address, write_data, read_data;
  logic [2:0] subfunction_3;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic txlog [0:4095];
  mmio_uart_tx #(.CLKS_PER_BIT(4), .BASE_ADDRESS(32'h0000_1000)) dut (
    .clk(clk), .reset(reset), .address(address), .write_data(write_data),
    .subfunction_3(subfunction_3), .request_write(request_write), .request_read(request_read),
    .clk_stall(clk_stall), .read_data(read_data), .decoding_error(decoding_error), .tx(tx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 4096) txlog[cyc] = tx;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          output int edge_no, output int waits);
    waits = 0;
    address = a;
    write_data = d;
    subfunction_3 = f;
    request_read = 1'b0;
    request_write = 1'b1;
    #1;
    while (clk_stall === 1'b1 && waits < 200) begin
      waits++;
      step();
      #1;
    end
    if (waits >= 200) chk("write_timeout", {31'd0, clk_stall}, 32'd0);
    step();
    edge_no = cyc;
    request_write = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d, output logic e);
    address = a;
    subfunction_3 = f;
    request_write = 1'b0;
    request_read = 1'b1;
    #1;
    d = read_data;
    e = decoding_error;
    request_read = 1'b0;
  endtask
  task automatic chk_frame(input string tag, input int s, input logic [7:0] b);
    logic [3:0] got;
    logic e;
    chk({tag, "_pre"}, {31'd0, txlog[s-1]}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      for (int j = 0; j < 4; j++) got[j] = txlog[s + 4*k + j];
      chk($sformatf("%s_bit%0d", tag, k), 32'(got), 32'({4{e}}));
    end
  endtask
  task automatic chk_quiet(input string tag, input int n);
    int q, zeros;
    q = cyc;
    zeros = 0;
    repeat (n + 1) step();
    for (int i = 0; i < n; i++) zeros += (txlog[q + i] !== 1'b1) ? 1 : 0;
    chk(tag, zeros, 32'd0);
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int e, w, m, e2, w2, e3, w3, o1, o2, r;
    address = '0;
    write_data = '0;
    subfunction_3 = '0;
    request_write = 1'b0;
    request_read = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_stall", {31'd0, clk_stall}, 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_err", {31'd0, decoding_error}, 32'd0);
    do_read(32'h1004, 3'b010, rd, er);
    chk("rst_status", rd, 32'd0);
    do_read(32'h1000, 3'b010, rd, er);
    chk("rst_txdata", rd, 32'd0);
    step();
    do_write(32'h1000, 32'h0000_0055, 3'b000, e, w);
    chk("sb_waits", w, 32'd0);
    chk("sb_tx_at_accept", {31'd0, tx}, 32'd1);
    do_read(32'h1004, 3'b010, rd, er);
    chk("sb_status_pending", rd, 32'd3);
    wait_cyc(e + 45);
    chk_frame("sb", e + 1, 8'h55);
    chk("sb_after", {31'd0, txlog[e + 41]}, 32'd1);
    do_read(32'h1004, 3'b010, rd, er);
    chk("sb_status_done", rd, 32'd0);
    step();
    do_write(32'h1000, 32'h1234_56A5, 3'b010, m, w);
    chk("b2b_w1_waits", w, 32'd0);
    do_write(32'h1000, 32'h0000_003C, 3'b010, e2, w2);
    chk("b2b_w2_waits", w2, 32'd1);
    chk("b2b_w2_edge", e2 - m, 32'd2);
    do_write(32'h1000, 32'h0000_00FF, 3'b010, e3, w3);
    chk("b2b_w3_waits", w3, 32'd39);
    chk("b2b_w3_edge", e3 - m, 32'd42);
    do_read(32'h1004, 3'b010, rd, er);
    chk("b2b_status", rd, 32'd3);
    chk("b2b_status_err", {31'd0, er}, 32'd0);
    do_read(32'h1000, 3'b010, rd, er);
    chk("b2b_readback", rd, 32'h0000_00FF);
    wait_cyc(m + 125);
    chk_frame("f_a5", m + 1, 8'hA5);
    chk_frame("f_3c", m + 41, 8'h3C);
    chk_frame("f_ff", m + 81, 8'hFF);
    chk("b2b_after", {31'd0, txlog[m + 121]}, 32'd1);
    address = 32'h1004;
    write_data = 32'h11;
    subfunction_3 = 3'b010;
    request_write = 1'b1;
    #1;
    chk("err_sw_status", {31'd0, decoding_error}, 32'd1);
    chk("err_sw_status_stall", {31'd0, clk_stall}, 32'd0);
    step();
    request_write = 1'b0;
    do_read(32'h1008, 3'b010, rd, er);
    chk("err_lw_1008", {31'd0, er}, 32'd1);
    chk("err_lw_1008_data", rd, 32'd0);
    address = 32'h1000;
    write_data = 32'hAA;
    subfunction_3 = 3'b011;
    request_write = 1'b1;
    #1;
    chk("err_f3_011", {31'd0, decoding_error}, 32'd1);
    chk("err_f3_011_stall", {31'd0, clk_stall}, 32'd0);
    step();
    request_write = 1'b0;
    do_read(32'h1000, 3'b001, rd, er);
    chk("err_lh_read", {31'd0, er}, 32'd1);
    chk("err_lh_read_data", rd, 32'd0);
    do_read(32'h1004, 3'b010, rd, er);
    chk("err_status", rd, 32'd0);
    do_read(32'h1000, 3'b100, rd, er);
    chk("err_readback", rd, 32'h0000_00FF);
    chk_quiet("err_no_frame", 20);
    do_write(32'h1000, 32'h81, 3'b000, o1, w);
    do_write(32'h1000, 32'h42, 3'b000, o2, w);
    chk("oow_fill_waits", w, 32'd1);
    address = 32'h2000;
    write_data = 32'h99;
    subfunction_3 = 3'b000;
    request_write = 1'b1;
    #1;
    chk("oow_stall", {31'd0, clk_stall}, 32'd0);
    chk("oow_err", {31'd0, decoding_error}, 32'd0);
    step();
    request_write = 1'b0;
    do_read(32'h2000, 3'b010, rd, er);
    chk("oow_read", rd, 32'd0);
    chk("oow_read_err", {31'd0, er}, 32'd0);
    do_read(32'h1004, 3'b010, rd, er);
    chk("oow_status", rd, 32'd3);
    do_read(32'h1000, 3'b010, rd, er);
    chk("oow_readback", rd, 32'h42);
    wait_cyc(o1 + 85);
    chk_frame("f_81", o1 + 1, 8'h81);
    chk_frame("f_42", o1 + 41, 8'h42);
    do_write(32'h1000, 32'h96, 3'b000, r, w);
    do_write(32'h1000, 32'h0F, 3'b000, e, w);
    wait_cyc(r + 18);
    chk("rst_mid_bit3", {31'd0, tx}, 32'd0);
    do_read(32'h1004, 3'b010, rd, er);
    chk("rst_mid_status_pre", rd, 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    do_read(32'h1004, 3'b010, rd, er);
    chk("rst_mid_status", rd, 32'd0);
    chk_quiet("rst_mid_quiet", 60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
